// File: rtl/rv32_param_reg_file_pkg.sv
// rf_pkg: shared definitions for the parametrised RV32 integer register file.
// Provides the RV32I/RV32E register counts, the 5-bit register index type,
// the scrub FSM state encoding and the illegal-index helper function.
package rf_pkg;

  localparam int RF_REGS_RV32I = 32;
  localparam int RF_REGS_RV32E = 16;
  localparam int RF_IDX_W      = 5;

  typedef logic [4:0] rf_idx_t;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_SCRUB = 1'b1
  } rf_state_t;

  // An index is illegal when it names a register beyond NUM_REGS-1. The index
  // is widened by one bit so the compare stays meaningful when NUM_REGS=32
  // (it then simply evaluates to 0).
  function automatic logic idx_illegal(input rf_idx_t idx, input int num_regs);
    return ({1'b0, idx} >= 6'(num_regs));
  endfunction

endpackage

// File: rtl/rv32_param_reg_file_if.sv
// rv32_param_reg_file_if: bus bundle between the register file and its user.
//   rs_idx/rs_data/rs_illegal : NUM_RD_PORTS combinational read ports
//   rd_idx/rd_wdata/rd_wen    : single write port, rd_illegal flags bad index
//   clr_req/busy              : scrub request pulse and scrub-in-progress
// master = register file user (decode/execute), slave = register file.
interface rv32_param_reg_file_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 5
);
  logic [NUM_RD_PORTS-1:0][IDX_W-1:0]  rs_idx;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rs_data;
  logic [NUM_RD_PORTS-1:0]             rs_illegal;
  logic [IDX_W-1:0]                    rd_idx;
  logic [DATA_W-1:0]                   rd_wdata;
  logic                                rd_wen;
  logic                                rd_illegal;
  logic                                clr_req;
  logic                                busy;

  modport master (
    output rs_idx, rd_idx, rd_wdata, rd_wen, clr_req,
    input  rs_data, rs_illegal, rd_illegal, busy
  );

  modport slave (
    input  rs_idx, rd_idx, rd_wdata, rd_wen, clr_req,
    output rs_data, rs_illegal, rd_illegal, busy
  );
endinterface

// File: rtl/rv32_param_reg_file_scrub.sv
// rf_scrub_ctrl: scrub state machine for the register file.
// After reset, or on clr_req while idle, walks ptr from 1 to NUM_REGS-1 and
// requests a zero write to each register, one per cycle.
// Ports:
//   CLK, RST (sync, active-high) : clock / reset (reset starts a scrub)
//   clr_req                      : scrub request, ignored while scrubbing
//   busy                         : scrub in progress
//   scrub_we, scrub_idx          : zero-write request and target register
module rf_scrub_ctrl
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_REGS_RV32I
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    clr_req,
  output logic    busy,
  output logic    scrub_we,
  output rf_idx_t scrub_idx
);

  localparam rf_idx_t LAST_IDX = rf_idx_t'(NUM_REGS - 1);

  rf_state_t r_state;
  rf_state_t w_state_nxt;
  rf_idx_t   r_ptr;
  rf_idx_t   w_ptr_nxt;

  // State and pointer register; reset always (re)starts a scrub at x1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RF_SCRUB;
      r_ptr   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic; clr_req only matters when idle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_SCRUB;
          w_ptr_nxt   = 5'd1;
        end else begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = r_ptr;
        end
      end
      RF_SCRUB: begin
        if (r_ptr == LAST_IDX) begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = r_ptr;
        end else begin
          w_state_nxt = RF_SCRUB;
          w_ptr_nxt   = r_ptr + 5'd1;
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_ptr_nxt   = 5'd1;
      end
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    busy      = (r_state == RF_SCRUB);
    scrub_we  = (r_state == RF_SCRUB);
    scrub_idx = r_ptr;
  end

endmodule

// File: rtl/rv32_param_reg_file.sv
// rv32_param_reg_file: parametrised RV32I/RV32E integer register file.
// Storage for x1..NUM_REGS-1 (x0 reads 0), NUM_RD_PORTS combinational read
// ports, one write port, illegal-index flags and a scrub FSM that zeroes all
// registers after reset or on clr_req. Reads return 0 while scrubbing.
// Ports:
//   CLK           : clock, rising edge
//   RST           : synchronous active-high reset (starts a scrub)
//   bus (slave)   : rs_idx/rs_data/rs_illegal, rd_idx/rd_wdata/rd_wen/
//                   rd_illegal, clr_req/busy
// Optional build macro RF_BYPASS_EN: forward a same-cycle legal write to any
// read port naming the same register. Without it, reads see the old value.
module rv32_param_reg_file
  import rf_pkg::*;
#(
  parameter int NUM_REGS     = RF_REGS_RV32I,
  parameter int DATA_W       = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int IDX_W        = RF_IDX_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  rv32_param_reg_file_if.slave  bus
);

  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

  logic    w_busy;
  logic    w_scrub_we;
  rf_idx_t w_scrub_idx;
  rf_idx_t w_rd_idx;
  logic    w_rd_idx_illegal;
  logic    w_wr_ok;

  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] w_rs_data;
  logic [NUM_RD_PORTS-1:0]             w_rs_illegal;

  rf_scrub_ctrl #(.NUM_REGS(NUM_REGS)) u_scrub (
    .CLK       (CLK),
    .RST       (RST),
    .clr_req   (bus.clr_req),
    .busy      (w_busy),
    .scrub_we  (w_scrub_we),
    .scrub_idx (w_scrub_idx)
  );

  // Write qualification: x0 writes are dropped silently, not flagged.
  always_comb begin
    w_rd_idx         = rf_idx_t'(bus.rd_idx);
    w_rd_idx_illegal = idx_illegal(w_rd_idx, NUM_REGS);
    w_wr_ok          = bus.rd_wen && !w_busy && (w_rd_idx != 5'd0) && !w_rd_idx_illegal;
  end

  // Storage update; scrub zero-writes take priority (user writes are already
  // blocked while busy). Storage itself has no reset.
  always_ff @(posedge CLK) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_scrub_we && (w_scrub_idx == rf_idx_t'(i))) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_wr_ok && (w_rd_idx == rf_idx_t'(i))) begin
        r_regs[i] <= bus.rd_wdata;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Read ports: mux, then force 0 for busy / x0 / illegal index.
  always_comb begin
    logic [DATA_W-1:0] v_raw;
    rf_idx_t           v_idx;
    w_rs_data    = {(NUM_RD_PORTS*DATA_W){1'b0}};
    w_rs_illegal = {NUM_RD_PORTS{1'b0}};
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      v_idx = rf_idx_t'(bus.rs_idx[p]);
      v_raw = {DATA_W{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
        v_raw = (v_idx == rf_idx_t'(i)) ? r_regs[i] : v_raw;
      end
      w_rs_illegal[p] = idx_illegal(v_idx, NUM_REGS);
      if (w_busy || w_rs_illegal[p] || (v_idx == 5'd0)) begin
        w_rs_data[p] = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
      end else if (w_wr_ok && (w_rd_idx == v_idx)) begin
        w_rs_data[p] = bus.rd_wdata;
`endif
      end else begin
        w_rs_data[p] = v_raw;
      end
    end
  end

  assign bus.rs_data    = w_rs_data;
  assign bus.rs_illegal = w_rs_illegal;
  assign bus.rd_illegal = bus.rd_wen && w_rd_idx_illegal;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_rv32_param_reg_file.sv
// Self-checking bench: an RV32I (32-register) and an RV32E (16-register)
// instance run in lockstep on the same stimulus, each compared every cycle
// against a behavioural model (array of register values plus a scrub
// countdown), followed by directed checks and randomized traffic.
module tb_rv32_param_reg_file;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int NP = 2;
  localparam int IW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rv32_param_reg_file_if #(.NUM_RD_PORTS(NP), .DATA_W(DW), .IDX_W(IW)) bus_i ();
  rv32_param_reg_file_if #(.NUM_RD_PORTS(NP), .DATA_W(DW), .IDX_W(IW)) bus_e ();

  rv32_param_reg_file #(.NUM_REGS(RF_REGS_RV32I), .DATA_W(DW), .NUM_RD_PORTS(NP), .IDX_W(IW)) dut_i (
    .CLK(CLK), .RST(RST), .bus(bus_i.slave));
  rv32_param_reg_file #(.NUM_REGS(RF_REGS_RV32E), .DATA_W(DW), .NUM_RD_PORTS(NP), .IDX_W(IW)) dut_e (
    .CLK(CLK), .RST(RST), .bus(bus_e.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, register contents and remaining busy cycles.
  int          nregs [2] = '{32, 16};
  logic [31:0] m_mem [2][32];
  int          m_left[2];

  // Last observed outputs (sampled mid-cycle) and busy-cycle counters.
  logic        last_busy [2];
  logic [31:0] last_data [2][NP];
  logic        last_ill  [2][NP];
  logic        last_rdill[2];
  int          busy_cnt  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_read(int d, logic [4:0] ridx, logic wen,
                                           logic [4:0] widx, logic [31:0] wd);
    if (m_left[d] > 0) return 32'd0;
    if (ridx == 5'd0 || int'(ridx) >= nregs[d]) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wen && widx == ridx) return wd;
`endif
    return m_mem[d][ridx];
  endfunction

  task automatic model_scrub(input int d);
    m_left[d] = nregs[d] - 1;
    for (int i = 0; i < 32; i++) m_mem[d][i] = 32'd0;
  endtask

  // One clock cycle: drive, check against model, clock edge, advance model.
  task automatic step(input logic rst, input logic clr, input logic wen,
                      input logic [4:0] widx, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic [4:0] ridx[NP];
    ridx[0] = ra;
    ridx[1] = rb;
    RST = rst;
    bus_i.clr_req = clr;  bus_e.clr_req = clr;
    bus_i.rd_wen = wen;   bus_e.rd_wen = wen;
    bus_i.rd_idx = widx;  bus_e.rd_idx = widx;
    bus_i.rd_wdata = wd;  bus_e.rd_wdata = wd;
    bus_i.rs_idx[0] = ra; bus_e.rs_idx[0] = ra;
    bus_i.rs_idx[1] = rb; bus_e.rs_idx[1] = rb;
    #2;
    last_busy[0] = bus_i.busy;        last_busy[1] = bus_e.busy;
    last_rdill[0] = bus_i.rd_illegal; last_rdill[1] = bus_e.rd_illegal;
    for (int p = 0; p < NP; p++) begin
      last_data[0][p] = bus_i.rs_data[p]; last_data[1][p] = bus_e.rs_data[p];
      last_ill[0][p]  = bus_i.rs_illegal[p]; last_ill[1][p] = bus_e.rs_illegal[p];
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_n%0d", nregs[d]), {31'd0, last_busy[d]}, {31'd0, m_left[d] > 0});
      chk($sformatf("rd_illegal_n%0d_idx%0d", nregs[d], widx), {31'd0, last_rdill[d]},
          {31'd0, wen && (int'(widx) >= nregs[d])});
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rs_data_n%0d_p%0d_idx%0d", nregs[d], p, ridx[p]), last_data[d][p],
            exp_read(d, ridx[p], wen, widx, wd));
        chk($sformatf("rs_illegal_n%0d_p%0d_idx%0d", nregs[d], p, ridx[p]), {31'd0, last_ill[d][p]},
            {31'd0, int'(ridx[p]) >= nregs[d]});
      end
      if (last_busy[d]) busy_cnt[d]++;
    end
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (rst) model_scrub(d);
      else if (m_left[d] > 0) m_left[d]--;
      else if (clr) model_scrub(d);
      else if (wen && widx != 5'd0 && int'(widx) < nregs[d]) m_mem[d][widx] = wd;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  initial begin
    bus_i.clr_req = 1'b0; bus_e.clr_req = 1'b0;
    bus_i.rd_wen = 1'b0;  bus_e.rd_wen = 1'b0;
    bus_i.rd_idx = '0;    bus_e.rd_idx = '0;
    bus_i.rd_wdata = '0;  bus_e.rd_wdata = '0;
    bus_i.rs_idx = '0;    bus_e.rs_idx = '0;

    // Initial reset: storage is unknown before it, so nothing is checked yet.
    #1 RST = 1'b1;
    @(posedge CLK);
    model_scrub(0);
    model_scrub(1);
    #1 RST = 1'b0;

    // Reset scrub length, then every register reads 0.
    busy_cnt = '{0, 0};
    repeat (40) idle(5'd1, 5'd15);
    chk("busy_len_rv32i", busy_cnt[0], 32'd31);
    chk("busy_len_rv32e", busy_cnt[1], 32'd15);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // Basic write/read and x0 behaviour.
    step(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    chk("x5_read", last_data[0][0], 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd5);
    chk("x0_write_not_illegal", {31'd0, last_rdill[0]}, 32'd0);
    idle(5'd0, 5'd0);
    chk("x0_reads_zero", last_data[0][0], 32'd0);

    // Index 20 is illegal only on the RV32E instance; x17 likewise.
    step(1'b0, 1'b0, 1'b1, 5'd20, 32'h0000CAFE, 5'd20, 5'd17);
    chk("rv32e_x20_rd_illegal", {31'd0, last_rdill[1]}, 32'd1);
    chk("rv32i_x20_rd_legal", {31'd0, last_rdill[0]}, 32'd0);
    idle(5'd20, 5'd17);
    chk("rv32e_x17_illegal", {31'd0, last_ill[1][1]}, 32'd1);
    chk("rv32e_x17_zero", last_data[1][1], 32'd0);
    chk("rv32i_x20_value", last_data[0][0], 32'h0000CAFE);

    // Fill, clear, write during busy, second clr mid-scrub.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9);
    busy_cnt = '{0, 0};
    for (int k = 0; k < 40; k++) begin
      if (k == 3) step(1'b0, 1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd4);
      else if (k == 9) step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
      else idle(5'd3, 5'd4);
    end
    chk("clr_busy_len_rv32i", busy_cnt[0], 32'd31);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // Same-cycle write and read of x7.
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
`ifdef RF_BYPASS_EN
    chk("x7_same_cycle", last_data[0][0], 32'hA5A5A5A5);
`else
    chk("x7_same_cycle", last_data[0][0], 32'h1);
`endif
    idle(5'd7, 5'd0);
    chk("x7_next_cycle", last_data[0][0], 32'hA5A5A5A5);

    // Reset at scrub cycle 20 restarts a full scrub without a gap.
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd1);
    busy_cnt = '{0, 0};
    for (int k = 0; k < 60; k++) step(k == 19, 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd1);
    chk("rst_mid_scrub_busy_len", busy_cnt[0], 32'd51);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 300) == 0, ($urandom % 60) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_param_reg_file.md
Name: rv32_param_reg_file

Overview:
Parametrised integer register file that replaces fixed RV32I/RV32E selection with one block sized by NUM_REGS: 32 for RV32I, 16 for RV32E.
- Configurable read-port count and data width.
- Flags illegal register indices.
- Contains a scrub state machine that zeroes all registers after reset or on request, one register per cycle.
- Sits in the decode/execute path wherever the existing register file is instantiated.

Parameters:
NUM_REGS, 32, architectural register count; legal values 16 or 32.
DATA_W, 32, register width in bits.
NUM_RD_PORTS, 2, independent combinational read ports; range 1..4.
IDX_W, 5, register index width; fixed at 5 regardless of NUM_REGS.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
rs_idx  in  NUM_RD_PORTS x IDX_W  read indices.
rs_data  out  NUM_RD_PORTS x DATA_W  read data.
rs_illegal  out  NUM_RD_PORTS  per-port flag: rs_idx >= NUM_REGS.
rd_idx  in  IDX_W  write index.
rd_wdata  in  DATA_W  write data.
rd_wen  in  1  write enable.
rd_illegal  out  1  rd_wen && rd_idx >= NUM_REGS.
clr_req  in  1  single-cycle pulse requesting a full scrub.
busy  out  1  scrub in progress.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset:
  - RST=1 at an edge forces state SCRUB and ptr=1.
  - Storage is not reset directly; it is cleared by the scrub.
  - After the reset edge, busy=1, all rs_data=0, and rs_illegal/rd_illegal follow their combinational definitions.
- States: IDLE, SCRUB.
- SCRUB:
  - Each cycle writes 0 to reg[ptr], then ptr+1.
  - When ptr==NUM_REGS-1 the write completes and the next state is IDLE.
  - Duration is NUM_REGS-1 cycles, so busy drops on the edge after ptr reaches NUM_REGS-1.
- IDLE: clr_req=1 gives SCRUB, ptr=1 at the next edge.
- clr_req while in SCRUB is ignored; the scrub does not restart.
- RST asserted mid-scrub restarts at ptr=1.
- Simultaneous clr_req and RST: RST wins; the result is the same as reset.
- During SCRUB: rd_wen is ignored (the write is dropped) and all rs_data=0.
- x0: reads always return 0. Writes to index 0 are discarded silently and are not illegal.
- Reads: combinational (zero latency) from the current storage.
- Writes: take effect at the rising edge when rd_wen=1, busy=0, rd_idx!=0 and rd_idx<NUM_REGS.
- Illegal indices:
  - Any index >= NUM_REGS (e.g. 16..31 when NUM_REGS=16) reads 0 and raises rs_illegal for that port.
  - An illegal write is suppressed and raises rd_illegal in the same cycle.
  - With NUM_REGS=32 the illegal flags are constant 0.
- Multiple read ports naming the same index return identical data.
- Storage reg[1..NUM_REGS-1] is DATA_W bits each; x0 has no storage.

Optional Feature:
RF_BYPASS_EN
- Defined: when a legal write (rd_wen, busy=0, rd_idx!=0, legal) has rd_idx==rs_idx[p] in the same cycle, rs_data[p]=rd_wdata combinationally (write-to-read forwarding).
- Undefined: the read returns the pre-write value; the new value is visible from the next cycle.
- Illegal-index and x0 rules are unchanged in both builds.

Decomposition:
- Package rf_pkg:
  - constants RF_REGS_RV32I=32, RF_REGS_RV32E=16;
  - typedef rf_idx_t (logic [4:0]);
  - enum rf_state_t {RF_IDLE, RF_SCRUB}.
- Sub-module rf_scrub_ctrl:
  - holds the FSM and pointer;
  - inputs CLK, RST, clr_req;
  - outputs busy, scrub_we, scrub_idx.
- The top level holds storage, the read muxes, the illegal checks and the bypass.

Test Plan:
- Reset scrub, NUM_REGS=32: pulse RST for 1 cycle -> busy=1 for exactly 31 cycles then 0; every rs_data reads 0 afterwards.
- Write/read: write x5=32'hDEADBEEF, next cycle read rs_idx[0]=5 -> 32'hDEADBEEF. Write x0=32'h1234 -> x0 reads 0 and rd_illegal=0.
- RV32E (NUM_REGS=16): write to x20 -> rd_illegal=1 and storage unchanged. Read x17 -> rs_data=0, rs_illegal=1. Scrub takes 15 cycles.
- Clear mid-run: fill x1..x31 with the value of their index, pulse clr_req -> busy for 31 cycles. A write issued during busy is dropped; all registers read 0 after. A second clr_req at scrub cycle 10 causes no extension.
- Same-cycle write and read of x7=32'hA5A5A5A5 (old value 32'h1): with RF_BYPASS_EN -> 32'hA5A5A5A5; without it -> 32'h1, then 32'hA5A5A5A5 next cycle.
- Reset mid-scrub: RST at scrub cycle 20 -> a full 31-cycle scrub restarts; busy stays continuously high.
